// File: rtl/logo_pkg.sv
// logo_pkg: glyph code constants, code-to-stroke-mask table and scroll FSM encoding.
package logo_pkg;
  localparam logic [2:0] CODE_BLANK = 3'd0;
  localparam logic [2:0] CODE_N     = 3'd1;
  localparam logic [2:0] CODE_Z     = 3'd2;
  localparam logic [2:0] CODE_O     = 3'd3;
  localparam logic [2:0] CODE_X     = 3'd4;
  localparam logic [2:0] CODE_L     = 3'd5;
  localparam logic [2:0] CODE_U     = 3'd6;
  localparam logic [2:0] CODE_C     = 3'd7;
  typedef enum logic [1:0] {MOVE_R, PAUSE_R, MOVE_L, PAUSE_L} state_t;
  // Mask bit order is {PD, ND, B, T, R, L}.
  function automatic logic [5:0] code_mask(input logic [2:0] code);
    case (code)
      CODE_N:  return 6'b010011;
      CODE_Z:  return 6'b101100;
      CODE_O:  return 6'b001111;
      CODE_X:  return 6'b110000;
      CODE_L:  return 6'b001001;
      CODE_U:  return 6'b001011;
      CODE_C:  return 6'b001101;
      default: return 6'b000000;
    endcase
  endfunction
endpackage

// File: rtl/glyph_stroke_hit.sv
// glyph_stroke_hit: combinational stroke test of one glyph box at local coordinates (lx, ly).
module glyph_stroke_hit
  import logo_pkg::*;
#(
  parameter int GLYPH_W = 40,
  parameter int STROKE  = 5
) (
  input  logic signed [11:0] lx,
  input  logic signed [11:0] ly,
  input  logic [2:0]         code,
  output logic               hit
);
  localparam logic signed [11:0] W = 12'(GLYPH_W);
  localparam logic signed [11:0] S = 12'(STROKE);
  logic signed [11:0] w_mx, w_nd, w_pd;
  logic [5:0] w_s;
  always_comb begin
    w_mx = W - 12'sd1 - lx;
    w_nd = lx - ly;
    w_pd = w_mx - ly;
    w_s  = {!w_pd[11] && w_pd < S, !w_nd[11] && w_nd < S, ly >= W - S, ly < S, lx >= W - S, lx < S};
    hit  = |(w_s & code_mask(code));
  end
endmodule

// File: rtl/logo_scroll_painter.sv
// logo_scroll_painter: ping-pong scrolling glyph logo with a 2-stage pixel-hit pipeline.
// Define LOGO_BLINK_EN to gate hit with a frame-counted blink.
module logo_scroll_painter
  import logo_pkg::*;
#(
  parameter int GLYPHS       = 4,
  parameter int GLYPH_W      = 40,
  parameter int STROKE       = 5,
  parameter int GAP          = 10,
  parameter int X0           = 500,
  parameter int Y0           = 550,
  parameter int OFFS_MAX     = 100,
  parameter int STEP         = 2,
  parameter int PAUSE_FRAMES = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [3*GLYPHS-1:0]   glyph_codes,
  output logic                  hit,
  output logic [10:0]           offset,
  output logic                  dir
);
  localparam int PW = $clog2(PAUSE_FRAMES + 2);
  localparam logic [PW-1:0] CNT_END = PW'(PAUSE_FRAMES);
  state_t r_state;
  logic [10:0] r_offset, w_up, w_dn;
  logic [11:0] w_sum;
  logic w_up_end, w_dn_end, r_dir, r_hit, w_vis;
  logic [PW-1:0] r_cnt;
  logic [GLYPHS-1:0][11:0] w_lx, r_lx;
  logic [11:0] w_ly, r_ly;
  logic [GLYPHS-1:0] w_inbox, r_inbox, w_stroke;
  always_comb begin
    w_sum    = {1'b0, r_offset} + 12'(STEP);
    w_up_end = w_sum >= 12'(OFFS_MAX);
    w_up     = w_up_end ? 11'(OFFS_MAX) : w_sum[10:0];
    w_dn_end = r_offset <= 11'(STEP);
    w_dn     = w_dn_end ? 11'd0 : r_offset - 11'(STEP);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= MOVE_R;
      r_offset <= '0;
      r_dir    <= 1'b0;
      r_cnt    <= '0;
    end else if (frame_start && enable)
      case (r_state)
        MOVE_R: begin
          r_offset <= w_up;
          if (w_up_end) begin
            r_state <= PAUSE_R;
            r_cnt   <= '0;
          end
        end
        PAUSE_R:
          if (r_cnt == CNT_END) begin
            r_state  <= w_dn_end ? PAUSE_L : MOVE_L;
            r_offset <= w_dn;
            r_dir    <= 1'b1;
            r_cnt    <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        MOVE_L: begin
          r_offset <= w_dn;
          if (w_dn_end) begin
            r_state <= PAUSE_L;
            r_cnt   <= '0;
          end
        end
        PAUSE_L:
          if (r_cnt == CNT_END) begin
            r_state  <= w_up_end ? PAUSE_R : MOVE_R;
            r_offset <= w_up;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= MOVE_R;
      endcase
  // Negative local coordinates wrap to large unsigned values, so one unsigned compare bounds each axis.
  assign w_ly = {1'b0, y} - 12'(Y0);
  for (genvar k = 0; k < GLYPHS; k++) begin : g_slot
    assign w_lx[k]    = {1'b0, x} - {1'b0, r_offset} - 12'(X0 + k * (GLYPH_W + GAP));
    assign w_inbox[k] = w_lx[k] < 12'(GLYPH_W) && w_ly < 12'(GLYPH_W);
    glyph_stroke_hit #(.GLYPH_W(GLYPH_W), .STROKE(STROKE)) u_hit (
      .lx(r_lx[k]), .ly(r_ly), .code(glyph_codes[3*k +: 3]), .hit(w_stroke[k])
    );
  end
`ifdef LOGO_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_END = BW'(BLINK_FRAMES - 1);
  logic [BW-1:0] r_blink_cnt;
  logic r_blink_vis;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (frame_start && enable) begin
      r_blink_cnt <= (r_blink_cnt == BLINK_END) ? '0 : r_blink_cnt + 1'b1;
      if (r_blink_cnt == BLINK_END) r_blink_vis <= !r_blink_vis;
    end
  assign w_vis = r_blink_vis;
`else
  assign w_vis = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_lx    <= '0;
      r_ly    <= '0;
      r_inbox <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_lx    <= w_lx;
      r_ly    <= w_ly;
      r_inbox <= w_inbox;
      r_hit   <= enable && w_vis && |(r_inbox & w_stroke);
    end
  assign hit    = r_hit;
  assign offset = r_offset;
  assign dir    = r_dir;
endmodule
